// File: rtl/eu_sequencer_if.sv
// eu_sequencer_if: control link between the microprogram sequencer and the RV32I execution unit
interface eu_sequencer_if;
  logic        run;
  logic [31:0] ifd;
  logic [4:0]  cc;
  logic [20:0] eucntl;
  logic [3:0]  opcntl;
  logic [31:0] imm;
  logic        halted;
  logic [15:0] retired;
  modport master (input run, ifd, cc, output eucntl, opcntl, imm, halted, retired);
  modport slave (output run, ifd, cc, input eucntl, opcntl, imm, halted, retired);
endinterface

// File: rtl/eu_sequencer.sv
// eu_sequencer: RV32I fetch/decode/execute sequencer emitting registered control words for the execution unit
module eu_sequencer #(
  parameter int START_WAIT   = 1,
  parameter bit ILLEGAL_HALT = 1
) (
  input logic            clk,
  input logic            rst_n,
  eu_sequencer_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_ST0, S_DISP, S_EX, S_WB, S_AGEN, S_MEM, S_WBL,
    S_STM, S_CMP, S_BR, S_LUI, S_JWB, S_HALT, S_SKIP
  } state_t;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111,
                         OP_AUI = 7'b0010111, OP_JAL = 7'b1101111;
  localparam logic [31:0] SW = 32'(START_WAIT);
  state_t state, nxt;
  logic [31:0] instr, cur, cnt;
  logic [31:0] i_imm, s_imm, u_imm, b_word, j_word;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        f7b, term;
  logic [1:0]  pcup, pcalu, adest, bdest;
  logic [2:0]  asrc, bsrc, alu, mem;
  logic        ld;
  logic [3:0]  op;
  logic [31:0] im;
  logic [20:0] eucntl_q;
  logic [3:0]  opcntl_q;
  logic [31:0] imm_q;
  logic        halted_q;
  logic [15:0] retired_q;
  logic        unused_cc;
  // while dispatching, decode straight from ifd since instr only captures it on the leaving edge
  assign cur    = state == S_DISP ? bus.ifd : instr;
  assign opc    = cur[6:0];
  assign f3     = cur[14:12];
  assign f7b    = cur[30];
  assign i_imm  = {{20{cur[31]}}, cur[31:20]};
  assign s_imm  = {{20{cur[31]}}, cur[31:25], cur[11:7]};
  assign u_imm  = {cur[31:12], 12'h000};
  assign b_word = {{20{cur[31]}}, cur[31], cur[7], cur[30:25], cur[11:8]};
  assign j_word = {{12{cur[31]}}, cur[31], cur[19:12], cur[20], cur[30:21]};
  assign term   = state inside {S_WB, S_WBL, S_STM, S_BR, S_LUI, S_JWB, S_SKIP};
  assign unused_cc = ^bus.cc[4:1];
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: nxt = (cnt == SW && bus.run) ? S_ST0 : S_IDLE;
      S_ST0:  nxt = S_DISP;
      S_DISP:
        if (bus.run)
          case (opc)
            OP_R, OP_I, OP_AUI, OP_JAL: nxt = S_EX;
            OP_LD, OP_ST:               nxt = S_AGEN;
            OP_BR:                      nxt = S_CMP;
            OP_LUI:                     nxt = S_LUI;
            default:                    nxt = ILLEGAL_HALT ? S_HALT : S_SKIP;
          endcase
      S_EX:   nxt = opc == OP_JAL ? S_JWB : S_WB;
      S_AGEN: nxt = opc == OP_LD ? S_MEM : S_STM;
      S_MEM:  nxt = S_WBL;
      S_CMP:  nxt = S_BR;
      S_HALT: nxt = S_HALT;
      default: nxt = S_DISP;
    endcase
  end
  always_comb begin
    pcup = 2'b00; pcalu = 2'b00; asrc = 3'b000; adest = 2'b00; bsrc = 3'b000;
    bdest = 2'b00; alu = 3'b000; mem = 3'b000; ld = 1'b0; op = 4'h0; im = 32'h0;
    case (nxt)
      S_ST0, S_SKIP: begin pcup = 2'b01; pcalu = 2'b01; end
      S_DISP: ld = state != S_DISP;
      S_EX:
        case (opc)
          OP_R:   begin asrc = 3'b001; bsrc = 3'b010; alu = 3'b001; op = {f7b, f3}; end
          OP_I:   begin asrc = 3'b001; bsrc = 3'b001; alu = 3'b010; im = i_imm; op = {f7b & (f3 == 3'b101), f3}; end
          OP_AUI: begin asrc = 3'b110; bsrc = 3'b001; alu = 3'b100; im = u_imm; end
          OP_JAL: begin asrc = 3'b110; alu = 3'b110; end
          default: ;
        endcase
      S_WB:   begin asrc = 3'b010; adest = 2'b10; pcup = 2'b01; pcalu = 2'b01; end
      S_AGEN: begin asrc = 3'b001; bsrc = 3'b001; alu = 3'b100; im = opc == OP_ST ? s_imm : i_imm; end
      S_MEM:  begin asrc = 3'b010; mem = 3'b010; op = {1'b0, f3}; end
      S_WBL:  begin asrc = 3'b100; adest = 2'b10; pcup = 2'b01; pcalu = 2'b01; end
      S_STM:  begin asrc = 3'b101; bsrc = 3'b100; mem = 3'b011; op = {1'b0, f3}; pcup = 2'b01; pcalu = 2'b01; end
      S_CMP:  begin asrc = 3'b001; bsrc = 3'b010; alu = 3'b101; op = {1'b0, f3}; end
      S_BR: begin
        pcup  = bus.cc[0] ? 2'b10 : 2'b01;
        pcalu = bus.cc[0] ? 2'b10 : 2'b01;
        im    = bus.cc[0] ? b_word : 32'h0;
      end
      S_LUI:  begin bsrc = 3'b001; bdest = 2'b10; im = u_imm; pcup = 2'b01; pcalu = 2'b01; end
      S_JWB:  begin asrc = 3'b010; adest = 2'b10; pcup = 2'b10; pcalu = 2'b10; im = j_word; end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      instr     <= 32'h0;
      cnt       <= 32'h0;
      eucntl_q  <= 21'h0;
      opcntl_q  <= 4'h0;
      imm_q     <= 32'h0;
      halted_q  <= 1'b0;
      retired_q <= 16'h0;
    end else begin
      state    <= nxt;
      if (state == S_IDLE && cnt != SW) cnt <= cnt + 32'd1;
      if (state == S_DISP && bus.run) instr <= bus.ifd;
      eucntl_q <= {pcup, pcalu, asrc, adest, bsrc, bdest, alu, mem, ld};
      opcntl_q <= op;
      imm_q    <= im;
      halted_q <= nxt == S_HALT;
      if (term) retired_q <= retired_q + 16'd1;
    end
  end
  assign bus.eucntl  = eucntl_q;
  assign bus.opcntl  = opcntl_q;
  assign bus.imm     = imm_q;
  assign bus.halted  = halted_q;
  assign bus.retired = retired_q;
endmodule

// File: tb/tb_eu_sequencer.sv
// tb_eu_sequencer: directed and random instruction streams checked against a per-instruction control-word table
module tb_eu_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int unsigned ret = 0;
  typedef struct packed { logic [20:0] eu; logic [3:0] op; logic [31:0] im; } step_t;
  step_t q[$];
  logic [6:0] ops [8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
  eu_sequencer_if bus();
  eu_sequencer #(.START_WAIT(1), .ILLEGAL_HALT(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [20:0] w(input int pu, pa, as, ad, bs, bd, al, me);
    logic [20:0] r;
    r = 21'h0;
    r[20:19] = pu[1:0]; r[18:17] = pa[1:0]; r[16:14] = as[2:0]; r[13:12] = ad[1:0];
    r[11:9] = bs[2:0]; r[8:7] = bd[1:0]; r[6:4] = al[2:0]; r[3:1] = me[2:0];
    return r;
  endfunction

  function automatic step_t st(input logic [20:0] eu, input logic [3:0] op, input logic [31:0] im);
    step_t s;
    s.eu = eu; s.op = op; s.im = im;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // expected words for every state between two dispatches, from the instruction-class table
  task automatic model(input logic [31:0] x, input logic c0);
    logic [6:0] opc = x[6:0];
    logic [3:0] f3 = {1'b0, x[14:12]};
    logic signed [31:0] iv = $signed(x[31:20]);
    logic signed [31:0] sv = $signed({x[31:25], x[11:7]});
    logic [31:0] uv = {x[31:12], 12'h000};
    logic signed [31:0] bv = $signed({x[31], x[7], x[30:25], x[11:8], 1'b0}) / 2;
    logic signed [31:0] jv = $signed({x[31], x[19:12], x[20], x[30:21], 1'b0}) / 2;
    step_t wb = st(w(1, 1, 2, 2, 0, 0, 0, 0), 4'h0, 32'h0);
    q.delete();
    case (opc)
      7'h33: begin q.push_back(st(w(0, 0, 1, 0, 2, 0, 1, 0), {x[30], x[14:12]}, 32'h0)); q.push_back(wb); end
      7'h13: begin
        q.push_back(st(w(0, 0, 1, 0, 1, 0, 2, 0), {x[30] && x[14:12] == 3'd5, x[14:12]}, iv));
        q.push_back(wb);
      end
      7'h17: begin q.push_back(st(w(0, 0, 6, 0, 1, 0, 4, 0), 4'h0, uv)); q.push_back(wb); end
      7'h6F: begin
        q.push_back(st(w(0, 0, 6, 0, 0, 0, 6, 0), 4'h0, 32'h0));
        q.push_back(st(w(2, 2, 2, 2, 0, 0, 0, 0), 4'h0, jv));
      end
      7'h03: begin
        q.push_back(st(w(0, 0, 1, 0, 1, 0, 4, 0), 4'h0, iv));
        q.push_back(st(w(0, 0, 2, 0, 0, 0, 0, 2), f3, 32'h0));
        q.push_back(st(w(1, 1, 4, 2, 0, 0, 0, 0), 4'h0, 32'h0));
      end
      7'h23: begin
        q.push_back(st(w(0, 0, 1, 0, 1, 0, 4, 0), 4'h0, sv));
        q.push_back(st(w(1, 1, 5, 0, 4, 0, 0, 3), f3, 32'h0));
      end
      7'h63: begin
        q.push_back(st(w(0, 0, 1, 0, 2, 0, 5, 0), f3, 32'h0));
        q.push_back(c0 ? st(w(2, 2, 0, 0, 0, 0, 0, 0), 4'h0, bv) : st(w(1, 1, 0, 0, 0, 0, 0, 0), 4'h0, 32'h0));
      end
      default: q.push_back(st(w(1, 1, 0, 0, 1, 2, 0, 0), 4'h0, uv));
    endcase
  endtask

  task automatic exec(input logic [31:0] x, input logic c0);
    model(x, c0);
    bus.ifd = x;
    bus.cc = {4'($urandom), c0};
    bus.run = 1'b1;
    foreach (q[i]) begin
      @(negedge clk);
      chk($sformatf("eucntl %h step %0d", x, i), 32'(bus.eucntl), 32'(q[i].eu));
      chk($sformatf("opcntl %h step %0d", x, i), 32'(bus.opcntl), 32'(q[i].op));
      chk($sformatf("imm %h step %0d", x, i), bus.imm, q[i].im);
      bus.ifd = $urandom;
    end
    ret++;
    @(negedge clk);
    chk($sformatf("dispatch after %h", x), 32'(bus.eucntl), 32'h1);
    chk($sformatf("retired after %h", x), 32'(bus.retired), 32'(16'(ret)));
  endtask

  task automatic stall(input int n);
    bus.run = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("stall eucntl", 32'(bus.eucntl), 32'h0);
    end
  endtask

  task automatic startup();
    bus.run = 1'b1;
    @(negedge clk);
    chk("reset eucntl", 32'(bus.eucntl), 32'h0);
    chk("reset opcntl", 32'(bus.opcntl), 32'h0);
    chk("reset imm", bus.imm, 32'h0);
    chk("reset halted", 32'(bus.halted), 32'h0);
    chk("reset retired", 32'(bus.retired), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle wait", 32'(bus.eucntl), 32'h0);
    @(negedge clk);
    chk("st0", 32'(bus.eucntl), 32'(w(1, 1, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    chk("first dispatch", 32'(bus.eucntl), 32'h1);
  endtask

  initial begin
    bus.run = 1'b1;
    bus.ifd = 32'h0;
    bus.cc = 5'h0;
    startup();
    exec(32'h007100B3, 1'b0);
    exec(32'hFCE20793, 1'b0);
    chk("addi imm value", q[0].im, 32'hFFFFFFCE);
    exec(32'h40315093, 1'b0);
    chk("srai opcntl value", 32'(q[0].op), 32'hD);
    exec(32'h0084A703, 1'b0);
    exec(32'h00E40423, 1'b0);
    exec(32'h01288163, 1'b1);
    chk("beq taken imm value", q[1].im, 32'h1);
    exec(32'h01288163, 1'b0);
    exec(32'h123452B7, 1'b0);
    exec(32'hFFDFF0EF, 1'b0);
    stall(2);
    exec(32'h00001517, 1'b1);
    for (int n = 0; n < 80; n++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(3, 0) == 0) stall($urandom_range(3, 1));
      exec({r[31:7], ops[$urandom_range(7, 0)]}, 1'($urandom));
    end
    bus.ifd = 32'h0084A703;
    bus.run = 1'b1;
    repeat (2) @(negedge clk);
    chk("load in mem", 32'(bus.eucntl), 32'(w(0, 0, 2, 0, 0, 0, 0, 2)));
    rst_n = 1'b0;
    #1;
    chk("async reset eucntl", 32'(bus.eucntl), 32'h0);
    chk("async reset imm", bus.imm, 32'h0);
    chk("async reset retired", 32'(bus.retired), 32'h0);
    ret = 0;
    startup();
    exec(32'h00E40423, 1'b0);
    bus.ifd = 32'h0000000B;
    @(negedge clk);
    chk("illegal halted", 32'(bus.halted), 32'h1);
    chk("illegal eucntl", 32'(bus.eucntl), 32'h0);
    bus.ifd = 32'h007100B3;
    for (int n = 0; n < 4; n++) begin
      bus.run = 1'($urandom);
      @(negedge clk);
      chk("halt sticky", 32'(bus.halted), 32'h1);
      chk("halt eucntl", 32'(bus.eucntl), 32'h0);
      chk("halt retired", 32'(bus.retired), 32'(16'(ret)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
